action_dispatcher: RTL and testbench

- Sits directly downstream of the click-action decoder.
- Consumes its 3-bit action code and drives the decoder's ACK input.
- Moves the board cursor with wrap-around, and issues reveal/flag commands to the board controller over a valid/ready handshake.
- Guarantees exactly one effect per button press: after acking, it waits for the action code to return to idle before accepting another.

---
 rtl/action_dispatcher_pkg.sv | 28 ++
 rtl/cursor_wrap_counter.sv | 34 +++
 rtl/action_dispatcher.sv | 115 +++++++++++
 tb/tb_action_dispatcher.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/action_dispatcher_pkg.sv
// Shared encodings for the click-action dispatcher: decoder action codes,
// board command ops and the dispatcher FSM states.
package action_dispatcher_pkg;

  localparam int unsigned ACT_W = 3;
  localparam int unsigned OP_W  = 2;

  // Must match the click-action decoder's output encoding
  localparam logic [ACT_W-1:0] ACT_NONE    = 3'b000;
  localparam logic [ACT_W-1:0] ACT_BTNC    = 3'b001;
  localparam logic [ACT_W-1:0] ACT_DBLBTNC = 3'b010;
  localparam logic [ACT_W-1:0] ACT_U       = 3'b100;
  localparam logic [ACT_W-1:0] ACT_R       = 3'b101;
  localparam logic [ACT_W-1:0] ACT_D       = 3'b110;
  localparam logic [ACT_W-1:0] ACT_L       = 3'b111;

  localparam logic [OP_W-1:0] CMD_NONE   = 2'b00;
  localparam logic [OP_W-1:0] CMD_REVEAL = 2'b01;
  localparam logic [OP_W-1:0] CMD_FLAG   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CMD     = 2'b01,
    ST_ACK     = 2'b10,
    ST_RELEASE = 2'b11
  } state_e;

endpackage

// File: rtl/cursor_wrap_counter.sv
// Up/down cursor index counter that wraps between 0 and LIMIT-1 by compare,
// so non-power-of-two board sizes work.
module cursor_wrap_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = (count_q == MAX) ? '0 : count_q + WIDTH'(1);
    end else if (dec_i) begin
      count_d = (count_q == '0) ? MAX : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/action_dispatcher.sv
// Turns decoder action codes into cursor moves and reveal/flag board commands,
// producing exactly one effect per press (ack, then wait for idle action).
module action_dispatcher
  import action_dispatcher_pkg::*;
#(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned ROW_W = 4,
  parameter int unsigned COL_W = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [ACT_W-1:0] action,
  output logic             action_ack,
  input  logic             game_active,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             cmd_valid,
  output logic [OP_W-1:0]  cmd_op,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  input  logic             cmd_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             row_inc, row_dec, col_inc, col_dec;
  logic             cmd_valid_q, cmd_valid_d;
  logic             ack_q, ack_d;
  logic [OP_W-1:0]  cmd_op_q, cmd_op_d;
  logic [ROW_W-1:0] cmd_row_q, cmd_row_d;
  logic [COL_W-1:0] cmd_col_q, cmd_col_d;

  cursor_wrap_counter #(.WIDTH(ROW_W), .LIMIT(ROWS)) u_row (
    .clk     (clk),
    .clear_n (clear_n),
    .inc_i   (row_inc),
    .dec_i   (row_dec),
    .count_o (cursor_row)
  );

  cursor_wrap_counter #(.WIDTH(COL_W), .LIMIT(COLS)) u_col (
    .clk     (clk),
    .clear_n (clear_n),
    .inc_i   (col_inc),
    .dec_i   (col_dec),
    .count_o (cursor_col)
  );

  // Next state, cursor steps and command payload capture
  always_comb begin
    state_d   = state_q;
    row_inc   = 1'b0;
    row_dec   = 1'b0;
    col_inc   = 1'b0;
    col_dec   = 1'b0;
    cmd_op_d  = cmd_op_q;
    cmd_row_d = cmd_row_q;
    cmd_col_d = cmd_col_q;
    unique case (state_q)
      ST_IDLE: begin
        if (action != ACT_NONE) begin
          state_d = ST_ACK;
          case (action)
            ACT_BTNC, ACT_DBLBTNC: begin
              if (game_active) begin
                state_d   = ST_CMD;
                cmd_op_d  = (action == ACT_BTNC) ? CMD_REVEAL : CMD_FLAG;
                cmd_row_d = cursor_row;
                cmd_col_d = cursor_col;
              end
            end
            ACT_U:   row_dec = 1'b1;
            ACT_D:   row_inc = 1'b1;
            ACT_L:   col_dec = 1'b1;
            ACT_R:   col_inc = 1'b1;
            default: ;
          endcase
        end
      end
      ST_CMD:     if (cmd_ready) state_d = ST_ACK;
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (action == ACT_NONE) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    cmd_valid_d = (state_d == ST_CMD);
    ack_d       = (state_d == ST_ACK);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      cmd_op_q    <= CMD_NONE;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      ack_q       <= ack_d;
      cmd_op_q    <= cmd_op_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
    end
  end

  assign action_ack = ack_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_row    = cmd_row_q;
  assign cmd_col    = cmd_col_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_action_dispatcher.sv
// Self-checking bench for action_dispatcher on a 10x16 board (non-power-of-two rows).
module tb_action_dispatcher;

  localparam int unsigned ROWS  = 10;
  localparam int unsigned COLS  = 16;
  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;

  localparam logic [2:0] A_NONE = 3'b000;
  localparam logic [2:0] A_BTNC = 3'b001;
  localparam logic [2:0] A_DBL  = 3'b010;
  localparam logic [2:0] A_UND  = 3'b011;
  localparam logic [2:0] A_U    = 3'b100;
  localparam logic [2:0] A_R    = 3'b101;
  localparam logic [2:0] A_D    = 3'b110;
  localparam logic [2:0] A_L    = 3'b111;

  logic             clk = 1'b0;
  logic             clear_n;
  logic [2:0]       action;
  logic             action_ack;
  logic             game_active;
  logic [ROW_W-1:0] cursor_row;
  logic [COL_W-1:0] cursor_col;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             cmd_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int mrow = 0;
  int mcol = 0;

  action_dispatcher #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .action      (action),
    .action_ack  (action_ack),
    .game_active (game_active),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .cmd_ready   (cmd_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_move(input logic [2:0] a);
    case (a)
      A_U: mrow = (mrow + ROWS - 1) % ROWS;
      A_D: mrow = (mrow + 1) % ROWS;
      A_L: mcol = (mcol + COLS - 1) % COLS;
      A_R: mcol = (mcol + 1) % COLS;
      default: ;
    endcase
  endtask

  task automatic do_move(input logic [2:0] a);
    action = a;
    step();
    model_move(a);
    action = A_NONE;
    step();
    step();
  endtask

  task automatic goto_cell(input int r, input int c);
    while (mrow != r) do_move(A_D);
    while (mcol != c) do_move(A_R);
  endtask

  task automatic test_reset();
    clear_n = 1'b0; action = A_NONE; game_active = 1'b0; cmd_ready = 1'b0;
    step(); step();
    checks++;
    if (cursor_row !== 4'd0 || cursor_col !== 4'd0) begin
      errors++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
    end
    checks++;
    if (cmd_valid !== 1'b0 || action_ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: valid=%b ack=%b busy=%b want 0/0/0", cmd_valid, action_ack, busy);
    end
    checks++;
    if (cmd_op !== 2'b00 || cmd_row !== 4'd0 || cmd_col !== 4'd0) begin
      errors++; $display("FAIL reset_cmd: op=%b row=%0d col=%0d want 00/0/0", cmd_op, cmd_row, cmd_col);
    end
    clear_n = 1'b1;
    mrow = 0; mcol = 0;
    step();
  endtask

  task automatic test_wrap_hold();
    int acks = 0;
    goto_cell(2, 15);
    action = A_R;
    for (int i = 0; i < 5; i++) begin
      step();
      if (action_ack === 1'b1) acks++;
      if (i == 0) begin
        checks++;
        if (cursor_col !== 4'd0) begin
          errors++; $display("FAIL wrap_right: col=%0d want 0", cursor_col);
        end
      end
    end
    mcol = 0;
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL hold_single_ack: acks=%0d want 1", acks);
    end
    checks++;
    if (cursor_col !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_no_repeat: col=%0d busy=%b want 0/1", cursor_col, busy);
    end
    action = A_NONE;
    step();
    action = A_R;
    step();
    model_move(A_R);
    checks++;
    if (cursor_col !== 4'd1 || action_ack !== 1'b1) begin
      errors++; $display("FAIL after_release: col=%0d ack=%b want 1/1", cursor_col, action_ack);
    end
    action = A_NONE;
    step(); step();
  endtask

  task automatic test_corner_wrap();
    goto_cell(0, 0);
    do_move(A_U);
    checks++;
    if (cursor_row !== 4'(ROWS - 1)) begin
      errors++; $display("FAIL wrap_up: row=%0d want %0d", cursor_row, ROWS - 1);
    end
    do_move(A_L);
    checks++;
    if (cursor_col !== 4'(COLS - 1)) begin
      errors++; $display("FAIL wrap_left: col=%0d want %0d", cursor_col, COLS - 1);
    end
    do_move(A_D);
    checks++;
    if (cursor_row !== 4'd0) begin
      errors++; $display("FAIL wrap_down: row=%0d want 0", cursor_row);
    end
  endtask

  task automatic test_cmd_wait();
    goto_cell(3, 7);
    game_active = 1'b1; cmd_ready = 1'b0; action = A_BTNC;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_op !== 2'b01 || cmd_row !== 4'd3 || cmd_col !== 4'd7 || action_ack !== 1'b0) begin
        errors++;
        $display("FAIL cmd_wait_hold%0d: valid=%b op=%b row=%0d col=%0d ack=%b want 1/01/3/7/0",
                 k, cmd_valid, cmd_op, cmd_row, cmd_col, action_ack);
      end
      cmd_ready = (k == 3);
      step();
    end
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || action_ack !== 1'b1) begin
      errors++; $display("FAIL cmd_wait_ack: valid=%b ack=%b want 0/1", cmd_valid, action_ack);
    end
    action = A_NONE;
    step(); step();
    checks++;
    if (busy !== 1'b0 || action_ack !== 1'b0) begin
      errors++; $display("FAIL cmd_wait_idle: busy=%b ack=%b want 0/0", busy, action_ack);
    end
  endtask

  task automatic test_back_to_back();
    game_active = 1'b1; cmd_ready = 1'b1; action = A_DBL;
    step();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 2'b10 || cmd_row !== 4'(mrow) || cmd_col !== 4'(mcol)) begin
      errors++; $display("FAIL zero_wait_cmd: valid=%b op=%b row=%0d col=%0d want 1/10/%0d/%0d",
                         cmd_valid, cmd_op, cmd_row, cmd_col, mrow, mcol);
    end
    action = A_U;
    step();
    checks++;
    if (cmd_valid !== 1'b0 || action_ack !== 1'b1) begin
      errors++; $display("FAIL zero_wait_ack: valid=%b ack=%b want 0/1", cmd_valid, action_ack);
    end
    step();
    action = A_NONE; cmd_ready = 1'b0;
    step(); step();
    checks++;
    if (cursor_row !== 4'(mrow) || cursor_col !== 4'(mcol)) begin
      errors++; $display("FAIL move_during_cmd: got (%0d,%0d) want (%0d,%0d)", cursor_row, cursor_col, mrow, mcol);
    end
  endtask

  task automatic test_inactive();
    int acks = 0;
    int valids = 0;
    game_active = 1'b0; cmd_ready = 1'b0;
    action = A_BTNC;
    for (int i = 0; i < 4; i++) begin
      step();
      if (action_ack === 1'b1) acks++;
      if (cmd_valid === 1'b1) valids++;
    end
    action = A_NONE; step(); step();
    action = A_UND;
    for (int i = 0; i < 3; i++) begin
      step();
      if (action_ack === 1'b1) acks++;
      if (cmd_valid === 1'b1) valids++;
    end
    action = A_NONE; step(); step();
    checks++;
    if (acks != 2 || valids != 0) begin
      errors++; $display("FAIL inactive_noop: acks=%0d valids=%0d want 2/0", acks, valids);
    end
    checks++;
    if (cursor_row !== 4'(mrow) || cursor_col !== 4'(mcol) || busy !== 1'b0) begin
      errors++; $display("FAIL inactive_state: got (%0d,%0d) busy=%b want (%0d,%0d) 0",
                         cursor_row, cursor_col, busy, mrow, mcol);
    end
  endtask

  task automatic test_random();
    logic [2:0] a;
    int delay;
    int hold;
    for (int n = 0; n < 80; n++) begin
      a = 3'($urandom_range(0, 7));
      game_active = 1'($urandom_range(0, 1));
      delay = int'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 3));
      cmd_ready = 1'b0;
      action = a;
      step();
      if (a == A_NONE) begin
        checks++;
        if (busy !== 1'b0 || action_ack !== 1'b0 || cmd_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_idle%0d: busy=%b ack=%b valid=%b want 0/0/0", n, busy, action_ack, cmd_valid);
        end
        continue;
      end
      if ((a == A_BTNC || a == A_DBL) && game_active) begin
        for (int d = 0; d <= delay; d++) begin
          checks++;
          if (cmd_valid !== 1'b1 || cmd_op !== ((a == A_BTNC) ? 2'b01 : 2'b10) ||
              cmd_row !== 4'(mrow) || cmd_col !== 4'(mcol)) begin
            errors++; $display("FAIL rnd_cmd%0d: valid=%b op=%b row=%0d col=%0d want 1/%0d/%0d/%0d",
                               n, cmd_valid, cmd_op, cmd_row, cmd_col, (a == A_BTNC) ? 1 : 2, mrow, mcol);
          end
          cmd_ready = (d == delay);
          game_active = 1'($urandom_range(0, 1));
          step();
        end
        cmd_ready = 1'b0;
      end else begin
        model_move(a);
      end
      checks++;
      if (action_ack !== 1'b1 || cmd_valid !== 1'b0 || cursor_row !== 4'(mrow) || cursor_col !== 4'(mcol)) begin
        errors++; $display("FAIL rnd_ack%0d: ack=%b valid=%b cur=(%0d,%0d) want 1/0 (%0d,%0d)",
                           n, action_ack, cmd_valid, cursor_row, cursor_col, mrow, mcol);
      end
      for (int h = 0; h < hold; h++) step();
      action = A_NONE;
      step(); step();
      checks++;
      if (busy !== 1'b0 || action_ack !== 1'b0 || cursor_row !== 4'(mrow) || cursor_col !== 4'(mcol)) begin
        errors++; $display("FAIL rnd_release%0d: busy=%b ack=%b cur=(%0d,%0d) want 0/0 (%0d,%0d)",
                           n, busy, action_ack, cursor_row, cursor_col, mrow, mcol);
      end
    end
  endtask

  task automatic test_reset_mid_cmd();
    int valids = 0;
    goto_cell(4, 5);
    game_active = 1'b1; cmd_ready = 1'b0; action = A_BTNC;
    step();
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_cmd: valid=%b want 1", cmd_valid);
    end
    clear_n = 1'b0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || action_ack !== 1'b0 || busy !== 1'b0 || cursor_row !== 4'd0 || cursor_col !== 4'd0) begin
      errors++; $display("FAIL async_reset: valid=%b ack=%b busy=%b cur=(%0d,%0d) want 0/0/0 (0,0)",
                         cmd_valid, action_ack, busy, cursor_row, cursor_col);
    end
    mrow = 0; mcol = 0;
    step();
    action = A_NONE; cmd_ready = 1'b1;
    clear_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cmd_valid === 1'b1) valids++;
    end
    checks++;
    if (valids != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL no_reissue: valid_cycles=%0d busy=%b want 0/0", valids, busy);
    end
    cmd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_hold();
    test_corner_wrap();
    test_cmd_wait();
    test_back_to_back();
    test_inactive();
    test_random();
    test_reset_mid_cmd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
